bus_mux_arb: RTL and testbench
==============================

Name: bus_mux_arb

Overview:
- Parametrised, registered N-source bus multiplexer for the datapath bus. Successor to the fixed 24-input select-driven bus mux.
- Two modes:
  - Forced: an encoded select chooses the source, as the control unit does today.
  - Arbitrated: sources request the bus and are granted round-robin, with optional multi-cycle lock.
- Adds valid, grant and select-error flags.
- The output is held when no source is driving.

Parameters:
- WIDTH, 32: bus width in bits.
- N_SRC, 24: number of sources, 2..32.
- SEL_W, $clog2(N_SRC): select width. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- mode  in  1  0 = forced select, 1 = round-robin arbitration
- sel  in  SEL_W  source index (forced mode)
- sel_valid  in  1  sel qualifies a transfer this cycle
- req  in  N_SRC  per-source bus request (arbitrated mode)
- lock  in  1  the current winner keeps the bus while its req stays high
- data_in  in  N_SRC*WIDTH  source i at data_in[i*WIDTH +: WIDTH]
- bus_contents  out  WIDTH  registered bus value
- bus_valid  out  1  bus_contents was loaded at the last edge
- grant  out  N_SRC  one-hot, source driving bus_contents; zero when none
- sel_err  out  1  one-cycle pulse: forced sel >= N_SRC

Behaviour:
- Reset (clr_n low, async):
  - bus_contents=0, bus_valid=0, grant=0, sel_err=0.
  - Round-robin pointer ptr=0, state=IDLE.
  - Deassertion takes effect at the next rising edge.
- Latency: 1 cycle. data_in is sampled at the same edge that registers grant. grant and bus_contents always refer to the same source.
- No transfer in a cycle:
  - bus_contents holds its value.
  - bus_valid=0, grant=0.
- Forced mode (mode=0):
  - sel_valid=1 and sel<N_SRC: load data_in[sel], bus_valid=1, grant=1<<sel.
  - sel_valid=1 and sel>=N_SRC: hold bus_contents, bus_valid=0, grant=0, sel_err=1 for one cycle.
  - sel_valid=0: no transfer, sel_err=0.
  - req and lock are ignored. ptr and state are unchanged, except that OWN is forced to IDLE (see below).
- Arbitrated mode (mode=1), state machine IDLE/OWN:
  - IDLE, req==0: no transfer.
  - IDLE, req!=0: the winner w is the first set bit scanning from ptr upward, wrapping at N_SRC-1 back to 0.
    - Load data_in[w], grant=1<<w, bus_valid=1, ptr <= (w+1) mod N_SRC.
    - If lock=1: owner<=w, go to OWN.
  - OWN, req[owner]=1 and lock=1: reload data_in[owner] every cycle, grant and bus_valid stay asserted. ptr is frozen.
  - OWN, req[owner]=0 or lock=0: release.
    - In that same cycle, arbitrate as in IDLE from the current ptr. The old owner is eligible only after all other requesters.
    - Go to OWN if the new winner has lock=1, else to IDLE.
  - sel, sel_valid and sel_err are ignored; sel_err=0.
- Mode changes:
  - mode 1->0 while in OWN: immediate release to IDLE, and the forced path drives this cycle.
  - mode 0->1: arbitration starts from the retained ptr.
- Simultaneous requests: exactly one grant per cycle, and grant is never multi-hot.
- Fairness: with all N_SRC requesting and lock=0, each source is granted exactly once every N_SRC cycles.
- No combinational path from any input to any output.

Decomposition:
- Shared package bus_pkg:
  - MODE_FORCED=1'b0, MODE_RR=1'b1.
  - State encoding IDLE=1'b0, OWN=1'b1.
  - Function for the one-hot of an index.
- Sub-module rr_arbiter (N parameter): purely combinational. Takes req and ptr; returns the winner index and an any-request flag.
- bus_mux_arb owns the registers, the FSM and the data selection.

Test Plan:
- Reset mid-transfer: assert clr_n=0 asynchronously mid-cycle while bus_contents=0xDEADBEEF -> all outputs 0 immediately, without waiting for a clock edge. First post-reset RR grant with req=all-ones goes to source 0.
- Forced select: mode=0, sel_valid=1; sel=3 with data_in[3]=0x12345678, then sel=23 with data_in[23]=0xA5A5A5A5:
  - After the 1st edge: bus_contents=0x12345678, grant=0x000008.
  - After the 2nd edge: bus_contents=0xA5A5A5A5, grant=0x800000.
- Bad select: mode=0, sel=24, sel_valid=1, previous bus 0xCAFE0001 -> bus_contents stays 0xCAFE0001, bus_valid=0, grant=0, sel_err=1 for exactly one cycle.
- Round-robin fairness: mode=1, req=0xFFFFFF, lock=0 for 48 cycles -> grants go 0,1,...,23,0,...,23. Each source is granted exactly twice, and grant is one-hot every cycle.
- Lock and release:
  - mode=1, req={5,9}, lock=1 -> source 5 is granted and held for 4 cycles while req[5]=1.
  - Drop req[5] -> the next cycle grants source 9.
  - Then lock=0 with req={5,9} -> source 5, then source 9, alternating.
- Mode switch while locked: in OWN on source 9, set mode=0, sel=2, sel_valid=1 -> the next edge gives grant=0x000004, bus_contents=data_in[2], state=IDLE. Returning to mode=1 resumes from ptr=10.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus multiplexer/arbiter.
package bus_pkg;

  // Upper bound on the number of bus sources.
  localparam int MAX_SRC = 32;

  // Source-selection modes.
  localparam logic MODE_FORCED = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Arbitration state: IDLE grants afresh each cycle, OWN keeps a locked winner.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // One-hot vector with bit idx set; the caller truncates it to its source count.
  function automatic logic [MAX_SRC-1:0] onehot(input int idx);
    logic [MAX_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping to 0.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N     = 24,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotated index back into source numbering; ptr + offset stays below 2*N.
  function automatic int wrap(input int s);
    return (s >= N) ? s - N : s;
  endfunction

  // Rotate requests so ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    winner = '0;
    any    = 1'b0;
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    for (int j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any    = 1'b1;
        winner = SEL_W'(wrap(int'(ptr) + j));
      end
    end
  end

endmodule

// File: rtl/bus_mux_arb.sv
// Registered N-source bus multiplexer: forced select or round-robin with lock.
module bus_mux_arb
  import bus_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_SRC = 24,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   sel_valid,
  input  logic [N_SRC-1:0]       req,
  input  logic                   lock,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]       bus_contents,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic                   sel_err
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] arb_winner;
  logic [SEL_W-1:0] arb_next;
  logic             arb_any;
  logic             sel_ok;
  logic [WIDTH-1:0] src [N_SRC];

  // Unpack the flat source bus into one word per source.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src[i] = data_in[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N     (N_SRC),
    .SEL_W (SEL_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_winner),
    .any    (arb_any)
  );

  // Pointer advance past the winner, and range check for the forced select.
  assign arb_next = (int'(arb_winner) == N_SRC - 1) ? '0 : arb_winner + 1'b1;
  assign sel_ok   = int'(sel) < N_SRC;

  // Source selection, arbitration FSM and all registered outputs.
  // A locked owner's ptr already points just past it, so on release the
  // ordinary scan from ptr naturally puts the old owner last.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      bus_contents <= '0;
      bus_valid    <= 1'b0;
      grant        <= '0;
      sel_err      <= 1'b0;
      ptr          <= '0;
      owner        <= '0;
      state        <= IDLE;
    end else begin
      // NOTE: flags default to "no transfer" and the branches below override them; bus_contents is deliberately not defaulted so it holds.
      bus_valid <= 1'b0;
      grant     <= '0;
      sel_err   <= 1'b0;
      if (mode == MODE_FORCED) begin
        state <= IDLE;
        if (sel_valid) begin
          if (sel_ok) begin
            bus_contents <= src[sel];
            bus_valid    <= 1'b1;
            grant        <= N_SRC'(onehot(int'(sel)));
          end else begin
            sel_err <= 1'b1;
          end
        end
      end else if (state == OWN && req[owner] && lock) begin
        bus_contents <= src[owner];
        bus_valid    <= 1'b1;
        grant        <= N_SRC'(onehot(int'(owner)));
      end else if (arb_any) begin
        bus_contents <= src[arb_winner];
        bus_valid    <= 1'b1;
        grant        <= N_SRC'(onehot(int'(arb_winner)));
        ptr          <= arb_next;
        owner        <= arb_winner;
        state        <= lock ? OWN : IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed, scoreboard-based bench for bus_mux_arb (24 sources, 32-bit bus).
module tb_bus_mux_arb;

  localparam int W = 32;
  localparam int N = 24;
  localparam int S = $clog2(N);

  logic           clk;
  logic           clr_n;
  logic           mode;
  logic [S-1:0]   sel;
  logic           sel_valid;
  logic [N-1:0]   req;
  logic           lock;
  logic [N*W-1:0] data_in;
  logic [W-1:0]   bus_contents;
  logic           bus_valid;
  logic [N-1:0]   grant;
  logic           sel_err;

  int tests = 0;
  int fails = 0;
  int gcount [N];

  typedef struct {
    string        tag;
    logic [W-1:0] bus;
    logic         valid;
    logic [N-1:0] grant;
    logic         err;
  } exp_t;

  exp_t sb [$];

  bus_mux_arb #(.WIDTH(W), .N_SRC(N)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .mode         (mode),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .req          (req),
    .lock         (lock),
    .data_in      (data_in),
    .bus_contents (bus_contents),
    .bus_valid    (bus_valid),
    .grant        (grant),
    .sel_err      (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] data_of(input int i);
    case (i)
      3:       return 32'h1234_5678;
      7:       return 32'hCAFE_0001;
      11:      return 32'hDEAD_BEEF;
      23:      return 32'hA5A5_A5A5;
      default: return 32'h5A00_0000 | (i * 32'h0001_0101);
    endcase
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, take one clock, then compare what the DUT registered.
  task automatic step(input string tag, input logic [W-1:0] bus, input logic valid,
                      input logic [N-1:0] gnt, input logic err);
    exp_t e;
    sb.push_back('{tag, bus, valid, gnt, err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".bus"},   64'(bus_contents), 64'(e.bus));
    check({e.tag, ".valid"}, 64'(bus_valid),    64'(e.valid));
    check({e.tag, ".grant"}, 64'(grant),        64'(e.grant));
    check({e.tag, ".err"},   64'(sel_err),      64'(e.err));
  endtask

  initial begin
    clr_n = 1'b0;
    mode = 1'b0;
    sel = '0;
    sel_valid = 1'b0;
    req = '0;
    lock = 1'b0;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = data_of(i);
    for (int i = 0; i < N; i++) gcount[i] = 0;

    #1;
    check("rst.bus",   64'(bus_contents), 64'd0);
    check("rst.valid", 64'(bus_valid),    64'd0);
    check("rst.grant", 64'(grant),        64'd0);
    check("rst.err",   64'(sel_err),      64'd0);
    #11 clr_n = 1'b1;

    // Forced select, including the last source.
    sel_valid = 1'b1;
    sel = 5'd3;
    step("fsel3", 32'h1234_5678, 1'b1, 24'h000008, 1'b0);
    sel = 5'd23;
    step("fsel23", 32'hA5A5_A5A5, 1'b1, 24'h800000, 1'b0);

    // Out-of-range select holds the bus and pulses sel_err once.
    sel = 5'd7;
    step("fsel7", 32'hCAFE_0001, 1'b1, oh(7), 1'b0);
    sel = 5'd24;
    step("badsel", 32'hCAFE_0001, 1'b0, '0, 1'b1);
    sel_valid = 1'b0;
    step("badsel_end", 32'hCAFE_0001, 1'b0, '0, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    sel_valid = 1'b1;
    sel = 5'd11;
    step("fsel11", 32'hDEAD_BEEF, 1'b1, oh(11), 1'b0);
    #2 clr_n = 1'b0;
    #1;
    check("arst.bus",   64'(bus_contents), 64'd0);
    check("arst.valid", 64'(bus_valid),    64'd0);
    check("arst.grant", 64'(grant),        64'd0);
    check("arst.err",   64'(sel_err),      64'd0);
    #2 clr_n = 1'b1;

    // Round-robin with everyone requesting; sel is ignored, first grant is source 0.
    mode = 1'b1;
    req = '1;
    lock = 1'b0;
    sel = 5'd31;
    sel_valid = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      step($sformatf("rr%0d", i), data_of(i % N), 1'b1, oh(i % N), 1'b0);
      for (int k = 0; k < N; k++) if (grant[k]) gcount[k]++;
    end
    for (int k = 0; k < N; k++) check($sformatf("rr_count%0d", k), 64'(gcount[k]), 64'd2);

    // Lock: source 5 holds the bus while it requests.
    sel_valid = 1'b0;
    req = oh(5) | oh(9);
    lock = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("lock5_%0d", i), data_of(5), 1'b1, oh(5), 1'b0);
    req = oh(9);
    step("lock9", data_of(9), 1'b1, oh(9), 1'b0);

    // Release: unlocked requesters alternate.
    req = oh(5) | oh(9);
    lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step($sformatf("alt%0d", i), data_of(5), 1'b1, oh(5), 1'b0);
      else            step($sformatf("alt%0d", i), data_of(9), 1'b1, oh(9), 1'b0);
    end

    // Lock on 9 again, then force source 2 while locked.
    req = oh(9);
    lock = 1'b1;
    step("relock9", data_of(9), 1'b1, oh(9), 1'b0);
    mode = 1'b0;
    sel = 5'd2;
    sel_valid = 1'b1;
    step("force2", data_of(2), 1'b1, 24'h000004, 1'b0);

    // Back to arbitration: the lock was dropped, so the scan resumes at ptr=10.
    mode = 1'b1;
    sel_valid = 1'b0;
    req = '1;
    step("resume10", data_of(10), 1'b1, oh(10), 1'b0);

    // No requests: bus holds, no grant.
    req = '0;
    lock = 1'b0;
    step("idle", data_of(10), 1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
